// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings, FSM states and default latencies for the multiply/divide unit
package mdu_pkg;
  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } md_op_e;
  typedef enum logic {IDLE, RUN} md_state_e;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  function automatic logic is_md(input logic [2:0] op);
    return ~op[2];
  endfunction
  function automatic logic is_div(input logic [2:0] op);
    return ~op[2] & op[1];
  endfunction
endpackage

// File: rtl/mdu_if.sv
// mdu_if: E-stage issue bus and HI/LO/status return for the multiply/divide unit
interface mdu_if;
  logic        start;
  logic        cancel;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, cancel, op, a, b, input busy, stall_req, hi, lo);
  modport slave  (input start, cancel, op, a, b, output busy, stall_req, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational signed/unsigned multiply and divide on latched operands
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        wr
);
  logic signed [63:0] ps;
  logic [63:0]        pu;
  logic [31:0]        d, qu, ru;
  logic signed [32:0] qs, rs;
  // Divisor of zero is replaced so the dividers never see it; wr suppresses the commit.
  assign d  = (b == 32'd0) ? 32'd1 : b;
  assign ps = 64'($signed(a)) * 64'($signed(b));
  assign pu = {32'd0, a} * {32'd0, b};
  // 33-bit signed divide keeps 0x80000000 / -1 representable; low word wraps.
  assign qs = 33'($signed(a)) / 33'($signed(d));
  assign rs = 33'($signed(a)) % 33'($signed(d));
  assign qu = a / d;
  assign ru = a % d;
  always_comb begin
    wr = ~(is_div(op) & (b == 32'd0));
    {hi, lo} = (op == OP_MULT)  ? ps :
               (op == OP_MULTU) ? pu :
               (op == OP_DIV)   ? {rs[31:0], qs[31:0]} : {ru, qu};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle MIPS-style multiply/divide unit with HI/LO registers
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic  clk,
  input logic  reset_n,
  mdu_if.slave m
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  md_state_e   state_q, state_d;
  logic [CW-1:0] cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q, r_hi, r_lo;
  logic        r_wr, iss, md_iss, done;
  assign m.busy      = state_q == RUN;
  assign iss         = m.start & ~m.cancel & ~m.busy;
  assign md_iss      = iss & is_md(m.op);
  assign done        = m.busy & (cnt == CW'(1));
  assign m.stall_req = reset_n & ((m.start & ~m.cancel & is_md(m.op)) | m.busy);
  assign m.hi        = hi_q;
  assign m.lo        = lo_q;
  mdu_arith u_arith (.op(op_q), .a(a_q), .b(b_q), .hi(r_hi), .lo(r_lo), .wr(r_wr));
  always_comb begin
    state_d = state_q;
    state_d = md_iss ? RUN : done ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt     <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (md_iss) begin
        op_q <= m.op;
        a_q  <= m.a;
        b_q  <= m.b;
        cnt  <= is_div(m.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
      end else if (m.busy) begin
        cnt <= cnt - CW'(1);
      end
      if (done && r_wr) begin
        hi_q <= r_hi;
        lo_q <= r_lo;
      end
      if (iss && m.op == OP_MTHI) hi_q <= m.a;
      if (iss && m.op == OP_MTLO) lo_q <= m.a;
    end
  end
endmodule
